// File: rtl/l1_tlb_miss_arbiter.sv
// Round-robin arbiter giving the I-TLB and D-TLB miss paths one shared L2-TLB/PTW refill port, one refill in flight.
// Accept at T -> l2 request at T+1, response at R -> pulse at R+1; requesters see ready=0 while busy or during sfence.
module l1_tlb_miss_arbiter #(
   parameter int VPN_W = 27,
   parameter int PPN_W = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             io_itlb_req_valid,
   output logic             io_itlb_req_ready,
   input  logic [VPN_W-1:0] io_itlb_req_vpn,
   input  logic [1:0]       io_itlb_req_prv,
   input  logic             io_dtlb_req_valid,
   output logic             io_dtlb_req_ready,
   input  logic [VPN_W-1:0] io_dtlb_req_vpn,
   input  logic [1:0]       io_dtlb_req_prv,
   output logic             io_l2_req_valid,
   input  logic             io_l2_req_ready,
   output logic [VPN_W-1:0] io_l2_req_vpn,
   output logic [1:0]       io_l2_req_prv,
   output logic             io_l2_req_src,
   input  logic             io_l2_resp_valid,
   input  logic [PPN_W-1:0] io_l2_resp_ppn,
   input  logic             io_l2_resp_pf,
   input  logic             io_sfence,
   output logic             io_itlb_resp_valid,
   output logic             io_dtlb_resp_valid,
   output logic [PPN_W-1:0] io_resp_ppn,
   output logic             io_resp_pf,
   output logic             io_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   typedef struct packed {
      logic [VPN_W-1:0] vpn;
      logic [1:0]       prv;
      logic             src;
   } req_t;

   state_t           state;
   req_t             req_q;
   logic             rr_last;
   logic             kill;
   logic             post_reset;
   logic             itlb_resp_q;
   logic             dtlb_resp_q;
   logic [PPN_W-1:0] ppn_q;
   logic             pf_q;
   logic             grant_i;
   logic             grant_d;

   // rr_last = 1 means D-TLB was served last, so I-TLB wins a tie
   always_comb begin
      grant_i = io_itlb_req_valid & (~io_dtlb_req_valid | rr_last);
      grant_d = io_dtlb_req_valid & (~io_itlb_req_valid | ~rr_last);
   end

   assign io_itlb_req_ready  = (state == IDLE) & grant_i & ~io_sfence;
   assign io_dtlb_req_ready  = (state == IDLE) & grant_d & ~io_sfence;
   assign io_l2_req_valid    = (state == ISSUE);
   assign io_l2_req_vpn      = req_q.vpn;
   assign io_l2_req_prv      = req_q.prv;
   assign io_l2_req_src      = req_q.src;
   assign io_itlb_resp_valid = itlb_resp_q;
   assign io_dtlb_resp_valid = dtlb_resp_q;
   assign io_resp_ppn        = ppn_q;
   assign io_resp_pf         = pf_q;
   assign io_busy            = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         req_q       <= '0;
         rr_last     <= 1'b1;
         kill        <= 1'b0;
         post_reset  <= 1'b1;
         itlb_resp_q <= 1'b0;
         dtlb_resp_q <= 1'b0;
         ppn_q       <= '0;
         pf_q        <= 1'b0;
      end else begin
         itlb_resp_q <= 1'b0;
         dtlb_resp_q <= 1'b0;
         case (state)
            IDLE: begin
               if (io_itlb_req_ready | io_dtlb_req_ready) begin
                  req_q.vpn <= io_dtlb_req_ready ? io_dtlb_req_vpn : io_itlb_req_vpn;
                  req_q.prv <= io_dtlb_req_ready ? io_dtlb_req_prv : io_itlb_req_prv;
                  req_q.src <= io_dtlb_req_ready;
                  rr_last   <= io_dtlb_req_ready;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               // the request stays up even when flushed; the answer is dropped later
               if (io_sfence) kill <= 1'b1;
               if (io_l2_req_ready) begin
                  state      <= WAIT;
                  post_reset <= 1'b0;
               end
            end
            WAIT: begin
               if (io_l2_resp_valid) begin
                  state <= IDLE;
                  kill  <= 1'b0;
                  if (!kill && !io_sfence) begin
                     itlb_resp_q <= ~req_q.src;
                     dtlb_resp_q <= req_q.src;
                     ppn_q       <= io_l2_resp_ppn;
                     pf_q        <= io_l2_resp_pf;
                  end
               end else if (io_sfence) begin
                  kill <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a response owed to a refill cut off by reset may still trickle in before the next issue
   resp_only_in_wait: assert property (@(posedge clk) disable iff (!reset_n)
      io_l2_resp_valid |-> (state == WAIT || post_reset));

endmodule

// File: tb/tb_l1_tlb_miss_arbiter.sv
// Bench for l1_tlb_miss_arbiter: directed transaction table, hand-written flush/stall/reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_l1_tlb_miss_arbiter;

   localparam int VPN_W = 27;
   localparam int PPN_W = 20;

   logic             clk;
   logic             reset_n;
   logic             io_itlb_req_valid;
   logic             io_itlb_req_ready;
   logic [VPN_W-1:0] io_itlb_req_vpn;
   logic [1:0]       io_itlb_req_prv;
   logic             io_dtlb_req_valid;
   logic             io_dtlb_req_ready;
   logic [VPN_W-1:0] io_dtlb_req_vpn;
   logic [1:0]       io_dtlb_req_prv;
   logic             io_l2_req_valid;
   logic             io_l2_req_ready;
   logic [VPN_W-1:0] io_l2_req_vpn;
   logic [1:0]       io_l2_req_prv;
   logic             io_l2_req_src;
   logic             io_l2_resp_valid;
   logic [PPN_W-1:0] io_l2_resp_ppn;
   logic             io_l2_resp_pf;
   logic             io_sfence;
   logic             io_itlb_resp_valid;
   logic             io_dtlb_resp_valid;
   logic [PPN_W-1:0] io_resp_ppn;
   logic             io_resp_pf;
   logic             io_busy;

   l1_tlb_miss_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .io_itlb_req_valid  (io_itlb_req_valid),
      .io_itlb_req_ready  (io_itlb_req_ready),
      .io_itlb_req_vpn    (io_itlb_req_vpn),
      .io_itlb_req_prv    (io_itlb_req_prv),
      .io_dtlb_req_valid  (io_dtlb_req_valid),
      .io_dtlb_req_ready  (io_dtlb_req_ready),
      .io_dtlb_req_vpn    (io_dtlb_req_vpn),
      .io_dtlb_req_prv    (io_dtlb_req_prv),
      .io_l2_req_valid    (io_l2_req_valid),
      .io_l2_req_ready    (io_l2_req_ready),
      .io_l2_req_vpn      (io_l2_req_vpn),
      .io_l2_req_prv      (io_l2_req_prv),
      .io_l2_req_src      (io_l2_req_src),
      .io_l2_resp_valid   (io_l2_resp_valid),
      .io_l2_resp_ppn     (io_l2_resp_ppn),
      .io_l2_resp_pf      (io_l2_resp_pf),
      .io_sfence          (io_sfence),
      .io_itlb_resp_valid (io_itlb_resp_valid),
      .io_dtlb_resp_valid (io_dtlb_resp_valid),
      .io_resp_ppn        (io_resp_ppn),
      .io_resp_pf         (io_resp_pf),
      .io_busy            (io_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // kill: 0 none, 1 sfence in WAIT, 2 sfence with the response, 3 sfence in ISSUE
   typedef struct {
      logic             iv;
      logic             dv;
      logic [VPN_W-1:0] vpn_i;
      logic [VPN_W-1:0] vpn_d;
      logic [1:0]       prv_i;
      logic [1:0]       prv_d;
      logic [PPN_W-1:0] ppn;
      int               kill;
      int               exp_src;
      logic             exp_pulse;
   } vec_t;

   vec_t vt[8];

   // reference model state
   int               own;
   bit               sent;
   bit               doomed;
   bit               last_d;
   logic [VPN_W-1:0] m_vpn;
   logic [1:0]       m_prv;
   int               pulse_src;
   logic [PPN_W-1:0] m_ppn;
   logic             m_pf;
   bit               gi;
   bit               gd;
   logic [PPN_W-1:0] last_ppn;
   logic             last_pf;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b1, 1'b0, 27'h1234, 27'h0,    2'd1, 2'd0, 20'hABCD, 0, 0, 1'b1};
      vt[1] = '{1'b1, 1'b1, 27'h111,  27'h222,  2'd0, 2'd3, 20'h00011, 0, 1, 1'b1};
      vt[2] = '{1'b1, 1'b1, 27'h333,  27'h444,  2'd2, 2'd1, 20'h22222, 0, 0, 1'b1};
      vt[3] = '{1'b1, 1'b1, 27'h555,  27'h666,  2'd3, 2'd0, 20'h33333, 0, 1, 1'b1};
      vt[4] = '{1'b0, 1'b1, 27'h0,    27'h777,  2'd0, 2'd1, 20'h44444, 1, 1, 1'b0};
      vt[5] = '{1'b1, 1'b1, 27'h888,  27'h999,  2'd1, 2'd2, 20'h55555, 2, 0, 1'b0};
      vt[6] = '{1'b1, 1'b0, 27'haaa,  27'h0,    2'd3, 2'd0, 20'h66666, 3, 0, 1'b0};
      vt[7] = '{1'b1, 1'b1, 27'hbbb,  27'hccc,  2'd0, 2'd3, 20'h77777, 0, 1, 1'b1};

      reset_n = 1'b0;
      io_itlb_req_valid = 1'b0; io_itlb_req_vpn = '0; io_itlb_req_prv = '0;
      io_dtlb_req_valid = 1'b0; io_dtlb_req_vpn = '0; io_dtlb_req_prv = '0;
      io_l2_req_ready = 1'b0; io_l2_resp_valid = 1'b0; io_l2_resp_ppn = '0;
      io_l2_resp_pf = 1'b0; io_sfence = 1'b0;
      repeat (2) cyc();
      chk("rst_busy", io_busy, 0);
      chk("rst_l2v", io_l2_req_valid, 0);
      chk("rst_l2vpn", io_l2_req_vpn, 0);
      chk("rst_pulse", {io_itlb_resp_valid, io_dtlb_resp_valid}, 0);
      chk("rst_ppn", io_resp_ppn, 0);
      reset_n = 1'b1;
      last_ppn = '0;
      last_pf = 1'b0;

      for (int k = 0; k < 8; k++) begin
         io_itlb_req_valid = vt[k].iv; io_itlb_req_vpn = vt[k].vpn_i; io_itlb_req_prv = vt[k].prv_i;
         io_dtlb_req_valid = vt[k].dv; io_dtlb_req_vpn = vt[k].vpn_d; io_dtlb_req_prv = vt[k].prv_d;
         @(negedge clk);
         chk("t_irdy", io_itlb_req_ready, vt[k].exp_src == 0);
         chk("t_drdy", io_dtlb_req_ready, vt[k].exp_src == 1);
         cyc();
         io_itlb_req_valid = 1'b0; io_dtlb_req_valid = 1'b0;
         io_l2_req_ready = 1'b1; io_sfence = (vt[k].kill == 3);
         @(negedge clk);
         chk("t_l2v", io_l2_req_valid, 1);
         chk("t_l2vpn", io_l2_req_vpn, vt[k].exp_src == 1 ? vt[k].vpn_d : vt[k].vpn_i);
         chk("t_l2prv", io_l2_req_prv, vt[k].exp_src == 1 ? vt[k].prv_d : vt[k].prv_i);
         chk("t_l2src", io_l2_req_src, vt[k].exp_src);
         cyc();
         io_l2_req_ready = 1'b0; io_sfence = (vt[k].kill == 1);
         @(negedge clk);
         chk("t_l2v_wait", io_l2_req_valid, 0);
         chk("t_busy_wait", io_busy, 1);
         cyc();
         io_sfence = (vt[k].kill == 2);
         io_l2_resp_valid = 1'b1; io_l2_resp_ppn = vt[k].ppn; io_l2_resp_pf = vt[k].ppn[0];
         cyc();
         io_sfence = 1'b0; io_l2_resp_valid = 1'b0;
         if (vt[k].exp_pulse) begin
            last_ppn = vt[k].ppn;
            last_pf = vt[k].ppn[0];
         end
         @(negedge clk);
         chk("t_ipulse", io_itlb_resp_valid, vt[k].exp_pulse && vt[k].exp_src == 0);
         chk("t_dpulse", io_dtlb_resp_valid, vt[k].exp_pulse && vt[k].exp_src == 1);
         chk("t_ppn", io_resp_ppn, last_ppn);
         chk("t_pf", io_resp_pf, last_pf);
         chk("t_busy_done", io_busy, 0);
         cyc();
      end

      // L2 stalls for 5 cycles while a D request waits
      io_itlb_req_valid = 1'b1; io_itlb_req_vpn = 27'h5A5A; io_itlb_req_prv = 2'd2;
      @(negedge clk);
      chk("stall_irdy", io_itlb_req_ready, 1);
      cyc();
      io_itlb_req_valid = 1'b0;
      io_dtlb_req_valid = 1'b1; io_dtlb_req_vpn = 27'h7E7E; io_dtlb_req_prv = 2'd1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("stall_l2v", io_l2_req_valid, 1);
         chk("stall_vpn", io_l2_req_vpn, 27'h5A5A);
         chk("stall_drdy", io_dtlb_req_ready, 0);
         chk("stall_busy", io_busy, 1);
         cyc();
      end
      io_l2_req_ready = 1'b1;
      cyc();
      io_l2_req_ready = 1'b0; io_sfence = 1'b1;
      cyc();
      io_sfence = 1'b0;
      cyc();
      io_l2_resp_valid = 1'b1; io_l2_resp_ppn = 20'h0BEEF; io_l2_resp_pf = 1'b1;
      cyc();
      io_l2_resp_valid = 1'b0;
      @(negedge clk);
      chk("kill_pulse", {io_itlb_resp_valid, io_dtlb_resp_valid}, 0);
      chk("kill_busy", io_busy, 0);
      chk("kill_ppn", io_resp_ppn, last_ppn);
      chk("kill_drdy", io_dtlb_req_ready, 1);
      cyc();
      io_dtlb_req_valid = 1'b0; io_l2_req_ready = 1'b1;
      @(negedge clk);
      chk("d_l2vpn", io_l2_req_vpn, 27'h7E7E);
      chk("d_l2src", io_l2_req_src, 1);
      cyc();
      io_l2_req_ready = 1'b0;
      io_l2_resp_valid = 1'b1; io_l2_resp_ppn = 20'h0F0F0; io_l2_resp_pf = 1'b0;
      cyc();
      io_l2_resp_valid = 1'b0;
      io_dtlb_req_valid = 1'b1; io_dtlb_req_vpn = 27'h1357; io_sfence = 1'b1;
      @(negedge clk);
      chk("d_pulse", io_dtlb_resp_valid, 1);
      chk("d_ipulse", io_itlb_resp_valid, 0);
      chk("d_ppn", io_resp_ppn, 20'h0F0F0);
      chk("sf_idle_drdy", io_dtlb_req_ready, 0);
      cyc();
      io_sfence = 1'b0;
      @(negedge clk);
      chk("sf_after_drdy", io_dtlb_req_ready, 1);
      cyc();
      io_dtlb_req_valid = 1'b0; io_l2_req_ready = 1'b1;
      cyc();
      io_l2_req_ready = 1'b0;

      // asynchronous reset in WAIT, then a stray response
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", io_busy, 0);
      chk("arst_l2v", io_l2_req_valid, 0);
      chk("arst_vpn", io_l2_req_vpn, 0);
      chk("arst_src", io_l2_req_src, 0);
      chk("arst_ppn", io_resp_ppn, 0);
      chk("arst_pulse", {io_itlb_resp_valid, io_dtlb_resp_valid}, 0);
      cyc();
      reset_n = 1'b1;
      cyc();
      io_l2_resp_valid = 1'b1; io_l2_resp_ppn = 20'h12345; io_l2_resp_pf = 1'b1;
      cyc();
      io_l2_resp_valid = 1'b0;
      io_itlb_req_valid = 1'b1; io_dtlb_req_valid = 1'b1;
      @(negedge clk);
      chk("stray_pulse", {io_itlb_resp_valid, io_dtlb_resp_valid}, 0);
      chk("stray_ppn", io_resp_ppn, 0);
      chk("stray_busy", io_busy, 0);
      chk("tie_irdy", io_itlb_req_ready, 1);
      chk("tie_drdy", io_dtlb_req_ready, 0);
      cyc();

      // randomized traffic from a fresh reset
      reset_n = 1'b0;
      io_itlb_req_valid = 1'b0; io_dtlb_req_valid = 1'b0;
      repeat (2) cyc();
      reset_n = 1'b1;
      own = -1; sent = 0; doomed = 0; last_d = 1;
      m_vpn = '0; m_prv = '0; pulse_src = -1; m_ppn = '0; m_pf = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         cyc();
         io_itlb_req_valid = 1'($urandom_range(0, 1));
         io_itlb_req_vpn   = VPN_W'($urandom);
         io_itlb_req_prv   = 2'($urandom_range(0, 3));
         io_dtlb_req_valid = 1'($urandom_range(0, 1));
         io_dtlb_req_vpn   = VPN_W'($urandom);
         io_dtlb_req_prv   = 2'($urandom_range(0, 3));
         io_l2_req_ready   = ($urandom_range(0, 3) != 0);
         io_sfence         = ($urandom_range(0, 9) == 0);
         io_l2_resp_valid  = (own >= 0 && sent) ? ($urandom_range(0, 2) == 0) : 1'b0;
         io_l2_resp_ppn    = PPN_W'($urandom);
         io_l2_resp_pf     = 1'($urandom_range(0, 1));
         @(negedge clk);
         gi = (own < 0) && !io_sfence && io_itlb_req_valid && (!io_dtlb_req_valid || last_d);
         gd = (own < 0) && !io_sfence && io_dtlb_req_valid && (!io_itlb_req_valid || !last_d);
         chk("r_irdy", io_itlb_req_ready, gi);
         chk("r_drdy", io_dtlb_req_ready, gd);
         chk("r_busy", io_busy, own >= 0);
         chk("r_l2v", io_l2_req_valid, own >= 0 && !sent);
         if (own >= 0 && !sent) begin
            chk("r_l2vpn", io_l2_req_vpn, m_vpn);
            chk("r_l2prv", io_l2_req_prv, m_prv);
            chk("r_l2src", io_l2_req_src, own);
         end
         chk("r_ipulse", io_itlb_resp_valid, pulse_src == 0);
         chk("r_dpulse", io_dtlb_resp_valid, pulse_src == 1);
         chk("r_ppn", io_resp_ppn, m_ppn);
         chk("r_pf", io_resp_pf, m_pf);

         pulse_src = -1;
         if (own < 0) begin
            if (gi || gd) begin
               own = gd ? 1 : 0;
               m_vpn = gd ? io_dtlb_req_vpn : io_itlb_req_vpn;
               m_prv = gd ? io_dtlb_req_prv : io_itlb_req_prv;
               sent = 0; doomed = 0; last_d = gd;
            end
         end else if (!sent) begin
            if (io_sfence) doomed = 1;
            if (io_l2_req_ready) sent = 1;
         end else if (io_l2_resp_valid) begin
            if (!doomed && !io_sfence) begin
               pulse_src = own;
               m_ppn = io_l2_resp_ppn;
               m_pf = io_l2_resp_pf;
            end
            own = -1;
         end else if (io_sfence) begin
            doomed = 1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
